// File: rtl/led7_pkg.sv
// Shared constants, types and helpers for the led7 4-digit scan controller.
package led7_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [3:0] AN_OFF    = 4'hF;

   // Active-low glyphs, bit order {a,b,c,d,e,f,g,dp}.
   localparam logic [7:0] SEG_0 = 8'h03;
   localparam logic [7:0] SEG_E = 8'h61;

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } state_e;

   typedef logic [1:0] digit_idx_t;

   // XOR of the a..g bits of all four digits; dp bits are excluded.
   function automatic logic frame_parity(input logic [31:0] frame);
      logic p;
      p = 1'b0;
      for (int d = 0; d < 4; d++) begin
         p = p ^ (^frame[d*8+1 +: 7]);
      end
      return p;
   endfunction

endpackage

// File: rtl/led7_slot_timer.sv
// Slot counter for the led7 scan controller: strobes the end of the blanking
// guard and the end of each digit slot.
module led7_slot_timer #(
   parameter int unsigned SLOT_CYCLES  = 50000,
   parameter int unsigned BLANK_CYCLES = 1000
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic blank_done_o,
   output logic slot_end_o
);

   localparam int unsigned CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign blank_done_o = (cnt_q == CW'(BLANK_CYCLES - 1));
   assign slot_end_o   = (cnt_q == CW'(SLOT_CYCLES - 1));

   always_comb begin
      cnt_d = slot_end_o ? '0 : cnt_q + CW'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its inputs regardless of block ordering.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/led7_scan_ctrl.sv
// 4-digit common-anode 7-segment scan controller with shadowed frame load.
// Optional dp parity indicator enabled by defining LED7_PARITY_EN.
module led7_scan_ctrl
   import led7_pkg::*;
#(
   parameter int unsigned SLOT_CYCLES  = 50000,
   parameter int unsigned BLANK_CYCLES = 1000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] data_i,
   input  logic        load_i,
   output logic        ready_o,
   output logic [7:0]  led7_seg_o,
   output logic [3:0]  led7_an_o,
   output logic        frame_o
`ifdef LED7_PARITY_EN
   ,output logic       parity_o
`endif
);

   logic blank_done;
   logic slot_end;
   logic boundary;

   state_e      state_q,  state_d;
   digit_idx_t  idx_q,    idx_d;
   logic [31:0] active_q, active_d;
   logic [31:0] shadow_q, shadow_d;
   logic        full_q,   full_d;
   logic [7:0]  seg_q,    seg_d;
   logic [3:0]  an_q,     an_d;
   logic        frame_q,  frame_d;
`ifdef LED7_PARITY_EN
   logic        parity_q, parity_d;
`endif

   led7_slot_timer #(
      .SLOT_CYCLES (SLOT_CYCLES),
      .BLANK_CYCLES(BLANK_CYCLES)
   ) u_slot_timer (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .blank_done_o(blank_done),
      .slot_end_o  (slot_end)
   );

   assign boundary = slot_end && (idx_q == digit_idx_t'(3));

   // NOTE: every signal gets its default at the top of the block so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      active_d = active_q;
      shadow_d = shadow_q;
      full_d   = full_q;
      frame_d  = boundary;
      an_d     = AN_OFF;
      seg_d    = SEG_BLANK;
`ifdef LED7_PARITY_EN
      parity_d = parity_q;
`endif

      case (state_q)
         BLANK:   if (blank_done) state_d = DRIVE;
         DRIVE:   if (slot_end)   state_d = BLANK;
         default: state_d = BLANK;
      endcase

      if (slot_end) begin
         idx_d = idx_q + digit_idx_t'(1);
      end

      // A full shadow can never coincide with an accept, so the swap and the
      // capture below are mutually exclusive within one cycle.
      if (boundary && full_q) begin
         active_d = shadow_q;
         full_d   = 1'b0;
`ifdef LED7_PARITY_EN
         parity_d = frame_parity(shadow_q);
`endif
      end

      if (load_i && !full_q) begin
         shadow_d = data_i;
         full_d   = 1'b1;
      end

      // Pins follow the current state, so they lag the state change by a cycle.
      if (state_q == DRIVE) begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = active_q[{idx_q, 3'b000} +: 8];
`ifdef LED7_PARITY_EN
         if ((idx_q == digit_idx_t'(0)) && parity_q) begin
            seg_d[0] = 1'b0;
         end
`endif
      end
   end

   // NOTE: the shadow data is reset along with its valid flag; it is small
   // enough that clearing it costs nothing and keeps reset state fully known.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= BLANK;
         idx_q    <= '0;
         active_q <= 32'hFFFF_FFFF;
         shadow_q <= 32'hFFFF_FFFF;
         full_q   <= 1'b0;
         seg_q    <= SEG_BLANK;
         an_q     <= AN_OFF;
         frame_q  <= 1'b0;
`ifdef LED7_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         active_q <= active_d;
         shadow_q <= shadow_d;
         full_q   <= full_d;
         seg_q    <= seg_d;
         an_q     <= an_d;
         frame_q  <= frame_d;
`ifdef LED7_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign ready_o    = ~full_q;
   assign led7_seg_o = seg_q;
   assign led7_an_o  = an_q;
   assign frame_o    = frame_q;
`ifdef LED7_PARITY_EN
   assign parity_o   = parity_q;
`endif

endmodule

// File: tb/tb_led7_scan_ctrl.sv
// Directed bench for led7_scan_ctrl with SLOT_CYCLES=8, BLANK_CYCLES=2.
// Parity checks are compiled in when LED7_PARITY_EN is defined.
module tb_led7_scan_ctrl;
   import led7_pkg::*;

   localparam int unsigned SLOT  = 8;
   localparam int unsigned BLNK  = 2;
   localparam int unsigned FRAME = 4 * SLOT;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] data_i = '0;
   logic        load_i = 1'b0;
   logic        ready_o;
   logic [7:0]  led7_seg_o;
   logic [3:0]  led7_an_o;
   logic        frame_o;
`ifdef LED7_PARITY_EN
   logic        parity_o;
`endif

   int checks = 0;
   int errors = 0;

   led7_scan_ctrl #(
      .SLOT_CYCLES (SLOT),
      .BLANK_CYCLES(BLNK)
   ) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .data_i    (data_i),
      .load_i    (load_i),
      .ready_o   (ready_o),
      .led7_seg_o(led7_seg_o),
      .led7_an_o (led7_an_o),
      .frame_o   (frame_o)
`ifdef LED7_PARITY_EN
      ,.parity_o (parity_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   // Advance one clock and settle past the edge before sampling or driving.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_pins(input string name, input logic [3:0] an,
                             input logic [7:0] seg, input logic ready);
      checks++;
      if ({led7_an_o, led7_seg_o, ready_o} !== {an, seg, ready}) begin
         errors++;
         $display("FAIL %s: an/seg/ready got %b/%h/%b expected %b/%h/%b",
                  name, led7_an_o, led7_seg_o, ready_o, an, seg, ready);
      end
   endtask

   task automatic check_ready(input string name, input logic ready);
      checks++;
      if (ready_o !== ready) begin
         errors++;
         $display("FAIL %s: ready_o got %b expected %b", name, ready_o, ready);
      end
   endtask

   // Steps until frame_o is seen (at least one step), bounded.
   task automatic wait_frame(input string name);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (frame_o !== 1'b1 && n < 3 * FRAME);
      checks++;
      if (frame_o !== 1'b1) begin
         errors++;
         $display("FAIL %s: frame_o got %b expected 1 within %0d cycles",
                  name, frame_o, 3 * FRAME);
      end
   endtask

   // Called on a frame_o cycle; checks the 32 following cycles of pins and
   // frame_o against exp. Optionally offers a load in the boundary cycle.
   task automatic verify_frame(input string name, input logic [31:0] exp,
                               input bit do_load, input logic [31:0] ld_data);
      logic [3:0] e_an;
      logic [7:0] e_seg;
      logic       e_fr;
      int         pos, d;
      for (int k = 1; k <= int'(FRAME); k++) begin
         if (do_load && k == int'(FRAME)) begin
            data_i = ld_data;
            load_i = 1'b1;
         end
         step();
         load_i = 1'b0;
         pos = (k - 1) % int'(SLOT);
         d   = (k - 1) / int'(SLOT);
         e_fr = (k == int'(FRAME));
         if (pos < int'(BLNK)) begin
            e_an  = 4'hF;
            e_seg = 8'hFF;
         end else begin
            e_an  = ~(4'b0001 << d);
            e_seg = exp[d*8 +: 8];
         end
         checks++;
         if ({led7_an_o, led7_seg_o, frame_o} !== {e_an, e_seg, e_fr}) begin
            errors++;
            $display("FAIL %s k=%0d: an/seg/frame got %b/%h/%b expected %b/%h/%b",
                     name, k, led7_an_o, led7_seg_o, frame_o, e_an, e_seg, e_fr);
         end
      end
   endtask

   task automatic load_word(input string name, input logic [31:0] w);
      data_i = w;
      load_i = 1'b1;
      step();
      load_i = 1'b0;
      check_ready(name, 1'b0);
   endtask

   task automatic test_reset();
      rst_i  = 1'b1;
      load_i = 1'b0;
      repeat (3) step();
      check_pins("reset_pins", 4'hF, 8'hFF, 1'b1);
      checks++;
      if (frame_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_frame: frame_o got %b expected 0", frame_o);
      end
      rst_i = 1'b0;
      step();
      check_pins("post_reset_c1", 4'hF, 8'hFF, 1'b1);
      step();
      check_pins("post_reset_c2", 4'hF, 8'hFF, 1'b1);
      step();
      check_pins("first_drive_c3", 4'b1110, 8'hFF, 1'b1);
   endtask

   task automatic test_load_and_backpressure();
      logic [31:0] f;
      f = {SEG_E, SEG_BLANK, SEG_BLANK, SEG_0};
      load_word("load_accept", f);
      data_i = 32'h0;
      load_i = 1'b1;
      step();
      load_i = 1'b0;
      check_ready("backpressure_ready", 1'b0);
      wait_frame("load_boundary");
      check_ready("ready_after_swap", 1'b1);
      verify_frame("load_frame", f, 1'b0, '0);
      check_ready("ready_frame_end", 1'b1);
   endtask

   task automatic test_back_to_back();
      logic [31:0] f_old, f_new;
      f_old = 32'h61FF_FF03;
      f_new = 32'h0361_0361;
      verify_frame("b2b_pre", f_old, 1'b1, f_new);
      check_ready("b2b_no_swap_ready", 1'b0);
      verify_frame("b2b_old_kept", f_old, 1'b0, '0);
      check_ready("b2b_swap_ready", 1'b1);
      verify_frame("b2b_new", f_new, 1'b0, '0);
   endtask

   task automatic test_mid_reset();
      load_word("midrst_load", 32'h0000_0000);
      repeat (18) step();
      check_pins("midrst_digit2", 4'b1011, 8'h61, 1'b0);
      rst_i = 1'b1;
      step();
      check_pins("midrst_blank", 4'hF, 8'hFF, 1'b1);
      step();
      rst_i = 1'b0;
      wait_frame("midrst_boundary");
      check_ready("midrst_ready", 1'b1);
      verify_frame("midrst_frame", 32'hFFFF_FFFF, 1'b0, '0);
   endtask

`ifdef LED7_PARITY_EN
   task automatic test_parity();
      load_word("par_even_load", 32'hFFFF_FF03);
      wait_frame("par_even_boundary");
      checks++;
      if (parity_o !== 1'b0) begin
         errors++;
         $display("FAIL par_even: parity_o got %b expected 0", parity_o);
      end
      verify_frame("par_even_frame", 32'hFFFF_FF03, 1'b0, '0);
      load_word("par_odd_load", 32'hFFFF_FF61);
      wait_frame("par_odd_boundary");
      checks++;
      if (parity_o !== 1'b1) begin
         errors++;
         $display("FAIL par_odd: parity_o got %b expected 1", parity_o);
      end
      verify_frame("par_odd_frame", 32'hFFFF_FF60, 1'b0, '0);
   endtask
`endif

   initial begin
      test_reset();
      test_load_and_backpressure();
      test_back_to_back();
      test_mid_reset();
`ifdef LED7_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
